// File: rtl/fcl_sum_sq_if.sv
// ---------------------------------------------------------------------------
// fcl_sum_sq_if
// Request/result bundle between a requester, the sum-of-squares stage and
// the downstream square-root stage.
//
// Signals:
//   start_in  : request strobe; operands are captured when the stage is ready
//   x_in      : signed X operand (DATA_WIDTH_IN bits)
//   y_in      : signed Y operand (DATA_WIDTH_IN bits)
//   done_in   : done strobe returned by the square-root stage
//   ready_out : stage is idle and will accept a request
//   start_out : one-cycle strobe telling the square-root stage data_out is valid
//   data_out  : unsigned x^2 + y^2 (DATA_WIDTH_OUT bits)
//
// Modports:
//   slave  : the sum-of-squares stage itself
//   master : whoever drives requests and consumes results
// ---------------------------------------------------------------------------
interface fcl_sum_sq_if #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 2 * DATA_WIDTH_IN
);

  logic                             start_in;
  logic signed [DATA_WIDTH_IN-1:0]  x_in;
  logic signed [DATA_WIDTH_IN-1:0]  y_in;
  logic                             done_in;
  logic                             ready_out;
  logic                             start_out;
  logic        [DATA_WIDTH_OUT-1:0] data_out;

  modport slave (
    input  start_in,
    input  x_in,
    input  y_in,
    input  done_in,
    output ready_out,
    output start_out,
    output data_out
  );

  modport master (
    output start_in,
    output x_in,
    output y_in,
    output done_in,
    input  ready_out,
    input  start_out,
    input  data_out
  );

endinterface

// File: rtl/fcl_sum_sq.sv
// ---------------------------------------------------------------------------
// fcl_sum_sq
// Computes x^2 + y^2 for two signed operands using a single bit-serial
// shift-add multiplier, then hands the result to a downstream square-root
// stage with a one-cycle start strobe.
//
// Sequence: IDLE -> SQ_X (DATA_WIDTH_IN cycles) -> SQ_Y (DATA_WIDTH_IN
// cycles) -> ISSUE (start_out for one cycle) -> WAIT (until done_in) -> IDLE.
// With WAIT_DONE = 0 the stage returns straight from ISSUE to IDLE.
//
// Ports:
//   clk_in   : system clock
//   reset_in : synchronous active-high reset
//   bus      : fcl_sum_sq_if slave modport (start_in, x_in, y_in, done_in,
//              ready_out, start_out, data_out)
//
// Parameters:
//   DATA_WIDTH_IN  : operand width in bits (4 or more)
//   DATA_WIDTH_OUT : result width, always 2 * DATA_WIDTH_IN
//   WAIT_DONE      : 1 = hold in WAIT until done_in, 0 = do not wait
// ---------------------------------------------------------------------------
module fcl_sum_sq #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 2 * DATA_WIDTH_IN,
  parameter int WAIT_DONE      = 1
) (
  input  logic         clk_in,
  input  logic         reset_in,
  fcl_sum_sq_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH_IN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQ_X  = 3'd1,
    SQ_Y  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Multiplier datapath: mplier shifts right so bit 0 is always the current
  // multiplier bit (LSB first); mcand shifts left so it always carries the
  // matching partial-product weight. Both start out holding the same
  // magnitude because we are squaring.
  logic [DATA_WIDTH_IN-1:0]  mplier;
  logic [DATA_WIDTH_OUT-1:0] mcand;
  logic [DATA_WIDTH_IN-1:0]  mag_y;
  logic [DATA_WIDTH_OUT-1:0] acc;
  logic [CNT_W-1:0]          cnt;

  // Two's-complement magnitude kept in the full operand width, so the most
  // negative value maps to 2^(W-1) without saturating.
  function automatic logic [DATA_WIDTH_IN-1:0] abs_mag(
    input logic [DATA_WIDTH_IN-1:0] v
  );
    logic [DATA_WIDTH_IN-1:0] r;
    r = v[DATA_WIDTH_IN-1] ? ((~v) + DATA_WIDTH_IN'(1)) : v;
    return r;
  endfunction

  // State register: reset wins over every other input.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The counter reaching zero marks the last multiplier
  // bit of the current square. done_in only matters while in WAIT, so a done
  // strobe coinciding with start_out is deliberately dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start_in) begin
          next_state = SQ_X;
        end
      end
      SQ_X: begin
        if (cnt == '0) begin
          next_state = SQ_Y;
        end
      end
      SQ_Y: begin
        if (cnt == '0) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = (WAIT_DONE != 0) ? WAIT : IDLE;
      end
      WAIT: begin
        if (bus.done_in) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Moore outputs: ready only in IDLE, start strobe only in ISSUE. Since
  // ISSUE always lasts exactly one cycle the strobe is one cycle wide.
  always_comb begin
    bus.ready_out = 1'b0;
    bus.start_out = 1'b0;
    case (state)
      IDLE:    bus.ready_out = 1'b1;
      ISSUE:   bus.start_out = 1'b1;
      default: begin
      end
    endcase
  end

  // Datapath. On accept, X's magnitude goes straight into the multiplier
  // registers and Y's magnitude is parked in mag_y. Each SQ cycle adds the
  // weighted multiplicand when the current multiplier bit is set. On the last
  // bit of X the registers are reloaded from mag_y so SQ_Y simply continues
  // accumulating on top of x^2. The accumulator is the output register, so
  // it holds the finished sum through ISSUE, WAIT and IDLE until the next
  // accept clears it.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mag_y  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            mplier <= abs_mag(bus.x_in);
            mcand  <= DATA_WIDTH_OUT'(abs_mag(bus.x_in));
            mag_y  <= abs_mag(bus.y_in);
            acc    <= '0;
            cnt    <= CNT_LAST;
          end
        end
        SQ_X, SQ_Y: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          if (cnt == '0) begin
            cnt    <= CNT_LAST;
            mcand  <= DATA_WIDTH_OUT'(mag_y);
            mplier <= mag_y;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The maximum sum 2^(2W-1) fits in DATA_WIDTH_OUT bits, so the
  // accumulator needs no overflow handling.
  assign bus.data_out = acc;

endmodule

// File: tb/tb_fcl_sum_sq.sv
// ---------------------------------------------------------------------------
// tb_fcl_sum_sq
// Self-checking bench for fcl_sum_sq. One instance waits for done_in, a
// second instance is built with WAIT_DONE = 0. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
//
// Cycle numbering: the rising edge that accepts a request is edge 0; the
// falling edge right after it is cycle 1. start_out is expected high at
// cycle 33 for 16-bit operands.
// ---------------------------------------------------------------------------
module tb_fcl_sum_sq;

  localparam int W  = 16;
  localparam int OW = 32;
  localparam int LAT = 2 * W + 1;

  logic clk_in = 1'b0;
  logic reset_in;

  always #5 clk_in = ~clk_in;

  fcl_sum_sq_if #(.DATA_WIDTH_IN(W), .DATA_WIDTH_OUT(OW)) bus ();
  fcl_sum_sq_if #(.DATA_WIDTH_IN(W), .DATA_WIDTH_OUT(OW)) bus0 ();

  fcl_sum_sq #(.DATA_WIDTH_IN(W), .DATA_WIDTH_OUT(OW), .WAIT_DONE(1)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  fcl_sum_sq #(.DATA_WIDTH_IN(W), .DATA_WIDTH_OUT(OW), .WAIT_DONE(0)) dut0 (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus0.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic [OW-1:0]       expected;
  } vec_t;

  vec_t vecs [10];

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Issue one request on the WAIT_DONE=1 instance (entered on a falling
  // edge with the stage idle) and return when start_out is seen or the
  // cycle budget runs out.
  task automatic applyStimulus(input logic signed [W-1:0] x,
                               input logic signed [W-1:0] y,
                               output int latency,
                               output logic [OW-1:0] result);
    bus.x_in     = x;
    bus.y_in     = y;
    bus.start_in = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    latency = 1;
    while (bus.start_out !== 1'b1 && latency < LAT + 8) begin
      @(negedge clk_in);
      latency++;
    end
    result = bus.data_out;
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [OW-1:0] res;
    int starts_seen;

    vecs[0] = '{x:  16'sd3,      y:  16'sd4,      expected: 32'd25};
    vecs[1] = '{x: -16'sd32768,  y: -16'sd32768,  expected: 32'h8000_0000};
    vecs[2] = '{x: -16'sd1,      y:  16'sd0,      expected: 32'd1};
    vecs[3] = '{x:  16'sd0,      y:  16'sd0,      expected: 32'd0};
    vecs[4] = '{x:  16'sd32767,  y:  16'sd32767,  expected: 32'd2147352578};
    vecs[5] = '{x: -16'sd32768,  y:  16'sd0,      expected: 32'd1073741824};
    vecs[6] = '{x:  16'sd100,    y: -16'sd200,    expected: 32'd50000};
    vecs[7] = '{x: -16'sd7,      y:  16'sd24,     expected: 32'd625};
    vecs[8] = '{x:  16'sd1,      y: -16'sd1,      expected: 32'd2};
    vecs[9] = '{x:  16'sd255,    y: -16'sd256,    expected: 32'd130561};

    // Reset state of both instances.
    reset_in      = 1'b1;
    bus.start_in  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.done_in   = 1'b0;
    bus0.start_in = 1'b0;
    bus0.x_in     = '0;
    bus0.y_in     = '0;
    bus0.done_in  = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset ready_out", bus.ready_out, 1);
    checkOutput("reset start_out", bus.start_out, 0);
    checkOutput("reset data_out", bus.data_out, 0);
    checkOutput("reset ready_out (no-wait)", bus0.ready_out, 1);
    checkOutput("reset data_out (no-wait)", bus0.data_out, 0);
    reset_in = 1'b0;
    @(negedge clk_in);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, lat, res);
      checkOutput($sformatf("vec%0d latency", i), lat, LAT);
      checkOutput($sformatf("vec%0d data_out", i), res, vecs[i].expected);
      checkOutput($sformatf("vec%0d ready in ISSUE", i), bus.ready_out, 0);
      @(negedge clk_in);
      checkOutput($sformatf("vec%0d ready in WAIT", i), bus.ready_out, 0);
      checkOutput($sformatf("vec%0d strobe width", i), bus.start_out, 0);
      bus.done_in = 1'b1;
      @(negedge clk_in);
      bus.done_in = 1'b0;
      checkOutput($sformatf("vec%0d ready after done", i), bus.ready_out, 1);
      checkOutput($sformatf("vec%0d data held", i), bus.data_out, vecs[i].expected);
    end

    // done_in coinciding with start_out must be ignored.
    applyStimulus(16'sd5, 16'sd12, lat, res);
    checkOutput("done-in-issue latency", lat, LAT);
    checkOutput("done-in-issue data", res, 169);
    bus.done_in = 1'b1;
    @(negedge clk_in);
    bus.done_in = 1'b0;
    checkOutput("done-in-issue still waiting", bus.ready_out, 0);
    @(negedge clk_in);
    checkOutput("done-in-issue still waiting 2", bus.ready_out, 0);
    bus.done_in = 1'b1;
    @(negedge clk_in);
    bus.done_in = 1'b0;
    checkOutput("done-in-issue ready after done", bus.ready_out, 1);

    // Reset at cycle 10 of SQ_X aborts the request.
    bus.x_in     = 16'sd3;
    bus.y_in     = 16'sd4;
    bus.start_in = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    repeat (9) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    checkOutput("abort ready_out", bus.ready_out, 1);
    checkOutput("abort data_out", bus.data_out, 0);
    starts_seen = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      if (bus.start_out === 1'b1) starts_seen++;
      @(negedge clk_in);
    end
    checkOutput("abort no start_out", starts_seen, 0);
    checkOutput("abort idle", bus.ready_out, 1);

    // start_in held high with operands changing every cycle; done pulsed
    // five cycles after each start_out. Acceptance times are predicted here.
    begin
      logic signed [W-1:0] px, py;
      logic [OW-1:0] exp_sum;
      bit rdy_exp;
      bit done_now;
      int dcnt;
      int ops;
      int k;
      int cyc;
      k = 0;
      ops = 0;
      dcnt = 0;
      done_now = 1'b0;
      px = W'(k * 37 - 500);
      py = W'(300 - k * 11);
      k++;
      bus.x_in = px;
      bus.y_in = py;
      exp_sum = OW'(longint'(px) * longint'(px) + longint'(py) * longint'(py));
      lat = 0;
      rdy_exp = 1'b0;
      bus.start_in = 1'b1;
      cyc = 0;
      while (ops < 3 && cyc < 200) begin
        @(negedge clk_in);
        cyc++;
        lat++;
        if (done_now) begin
          bus.done_in = 1'b0;
          done_now = 1'b0;
          rdy_exp = 1'b1;
        end
        checkOutput($sformatf("held-start ready cyc%0d", cyc), bus.ready_out, rdy_exp);
        if (bus.start_out === 1'b1) begin
          checkOutput($sformatf("held-start op%0d latency", ops), lat, LAT);
          checkOutput($sformatf("held-start op%0d data", ops), bus.data_out, exp_sum);
          ops++;
          dcnt = 5;
        end else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.done_in = 1'b1;
            done_now = 1'b1;
          end
        end
        if (ops < 3) begin
          px = W'(k * 37 - 500);
          py = W'(300 - k * 11);
          k++;
          bus.x_in = px;
          bus.y_in = py;
          if (rdy_exp) begin
            exp_sum = OW'(longint'(px) * longint'(px) + longint'(py) * longint'(py));
            lat = 0;
            rdy_exp = 1'b0;
          end
        end
      end
      checkOutput("held-start ops completed", ops, 3);
      bus.start_in = 1'b0;
      @(negedge clk_in);
      bus.done_in = 1'b1;
      @(negedge clk_in);
      bus.done_in = 1'b0;
      checkOutput("held-start back to idle", bus.ready_out, 1);
    end

    // WAIT_DONE = 0 instance: no WAIT state, done_in has no effect.
    begin
      int lat0;
      bus0.done_in  = 1'b1;
      bus0.x_in     = 16'sd100;
      bus0.y_in     = -16'sd200;
      bus0.start_in = 1'b1;
      @(negedge clk_in);
      bus0.start_in = 1'b0;
      lat0 = 1;
      while (bus0.start_out !== 1'b1 && lat0 < LAT + 8) begin
        @(negedge clk_in);
        lat0++;
      end
      checkOutput("no-wait latency", lat0, LAT);
      checkOutput("no-wait data", bus0.data_out, 50000);
      @(negedge clk_in);
      checkOutput("no-wait ready next cycle", bus0.ready_out, 1);
      checkOutput("no-wait strobe width", bus0.start_out, 0);
      checkOutput("no-wait data held", bus0.data_out, 50000);
      bus0.done_in = 1'b0;
    end

    // Random operand pairs; a simple square-root consumer answers with
    // done_in one cycle after each start_out.
    for (int n = 0; n < 1000; n++) begin
      logic signed [W-1:0] rx, ry;
      logic [OW-1:0] rexp;
      rx = W'($urandom);
      ry = W'($urandom);
      if (n % 16 == 0) rx = -16'sd32768;
      if (n % 16 == 8) ry = 16'sd32767;
      rexp = OW'(longint'(rx) * longint'(rx) + longint'(ry) * longint'(ry));
      applyStimulus(rx, ry, lat, res);
      checkOutput($sformatf("rand%0d latency", n), lat, LAT);
      checkOutput($sformatf("rand%0d x=%0d y=%0d", n, rx, ry), res, rexp);
      @(negedge clk_in);
      bus.done_in = 1'b1;
      @(negedge clk_in);
      bus.done_in = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
